kendall_seq_ctrl: RTL and testbench
===================================

// Module: kendall_seq_ctrl
// PURPOSE
//   Sequential Kendall-rank engine for streamed 4-point (x,y) sets.
//   - Buffers four points through a valid/ready input port.
//   - Schedules the 6 point pairs onto ONE shared x/y "smaller-than" comparator
//     pair, one pair per cycle, and counts concordant pairs.
//   - Emits tau*6 = 2*C-6 as a signed 4-bit result through a valid/ready output port.
//   - Low-area, time-multiplexed alternative to the fully parallel 12-comparator datapath.
// PARAMETERS
//   DW  4  coordinate width in bits (unsigned); point count fixed at 4, pair count fixed at 6
// PORTS
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   in_x/in_y carry a point
//   in_ready   out  1   block accepts a point this cycle
//   in_x       in   DW  point x coordinate, unsigned
//   in_y       in   DW  point y coordinate, unsigned
//   out_valid  out  1   kendall/conc_cnt valid
//   out_ready  in   1   consumer takes result
//   kendall    out  4   2*C-6, two's complement, range -6..+6
//   conc_cnt   out  3   C, concordant pair count, 0..6
//   busy       out  1   high in CALC state
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=LOAD, pt_idx=0, pair_idx=0, acc=0,
//     in_ready=1, out_valid=0, kendall=0, conc_cnt=0, busy=0, point buffer=0.
//     A reset asserted mid-LOAD or mid-CALC discards all partial data.
//   - State LOAD: in_ready=1.
//     - Accept when in_valid&&in_ready: store into buf[pt_idx]; pt_idx++.
//     - Accept with pt_idx==3 -> CALC, with pt_idx=0, pair_idx=0, acc=0.
//     - in_valid=0 cycles: hold state, no store.
//   - State CALC: in_ready=0, busy=1. Six cycles, pair_idx 0..5.
//     - Pair order: (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) as (i,j).
//     - sx = (x_i < x_j), sy = (y_i < y_j); strict unsigned compare, so a tie yields 0.
//     - Concordant = ~(sx ^ sy); acc += concordant. Width: 3-bit acc, cannot exceed 6.
//     - pair_idx==5 -> DONE. Register conc_cnt = final acc (including the last pair),
//       kendall = {acc_final,1'b0} - 4'd6 (mod 16), out_valid=1.
//     - in_valid is ignored during CALC.
//   - State DONE: out_valid=1; kendall and conc_cnt held stable; in_ready=0.
//     - out_ready=1 -> LOAD next cycle, with out_valid=0 and in_ready=1.
//     - kendall and conc_cnt keep their last value until the next DONE.
//     - No input overlap: the next set's first point is accepted no earlier than
//       the cycle after the out handshake.
//   - Latency: 4th-point accept at edge E; CALC occupies E+1..E+6;
//     out_valid=1 after edge E+6.
//     Minimum throughput: one set per 4+6+1 = 11 cycles.
//   - No combinational path from in_valid/out_ready to in_ready/out_valid;
//     both are decoded from registered state.
// TESTING
//   - Monotone set (0,0),(1,1),(2,2),(3,3), back-to-back valid -> conc_cnt=6,
//     kendall=4'b0110; out_valid 6 edges after the 4th accept.
//   - Anti set (0,3),(1,2),(2,1),(3,0) -> conc_cnt=0, kendall=4'b1010 (-6).
//   - Mixed set (0,1),(1,0),(2,3),(3,2) -> C=4, kendall=4'b0010 (+2).
//     Ties (5,0),(5,1),(5,2),(5,3) -> C=0, kendall=-6.
//     All-equal (7,7)x4 -> C=6, kendall=+6.
//   - Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, kendall stay
//     stable, in_ready=0, in_valid pulses ignored; release -> in_ready=1 next cycle.
//   - Gapped input (in_valid toggling 1,0,0,1,...) -> only valid beats stored,
//     same result as back-to-back.
//     in_valid held high during CALC -> no extra points captured.
//   - Assert rst_n=0 at CALC cycle 3 -> all outputs reset immediately.
//     Next full set after release computes correctly (monotone -> +6).

Source files
------------

// File: rtl/kendall_seq_ctrl.sv
// Sequential Kendall-rank engine: buffers four (x,y) points, then walks the six
// point pairs through one shared x/y comparator pair and reports 2*C-6.
module kendall_seq_ctrl #(
   parameter int DW = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DW-1:0]        in_x,
   input  logic [DW-1:0]        in_y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [3:0]    kendall,
   output logic [2:0]           conc_cnt,
   output logic                 busy
);

   typedef enum logic [1:0] {S_LOAD, S_CALC, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [1:0]         pt_idx_q, pt_idx_d;
   logic [2:0]         pair_idx_q, pair_idx_d;
   logic [2:0]         acc_q, acc_d;
   logic [DW-1:0]      x_q [4];
   logic [DW-1:0]      y_q [4];
   logic [DW-1:0]      x_d [4];
   logic [DW-1:0]      y_d [4];
   logic signed [3:0]  kendall_q, kendall_d;
   logic [2:0]         conc_q, conc_d;

   logic [1:0]         pi, pj;
   logic               sx, sy, concordant;
   logic [2:0]         acc_sum;

   // tau*6 = 2*C - 6, wrapping mod 16 into the signed 4-bit result
   function automatic logic signed [3:0] tau6(input logic [2:0] c);
      return $signed({c, 1'b0}) - 4'sd6;
   endfunction

   always_comb begin
      pi = 2'd2;
      pj = 2'd3;
      case (pair_idx_q)
         3'd0:    begin pi = 2'd0; pj = 2'd1; end
         3'd1:    begin pi = 2'd0; pj = 2'd2; end
         3'd2:    begin pi = 2'd0; pj = 2'd3; end
         3'd3:    begin pi = 2'd1; pj = 2'd2; end
         3'd4:    begin pi = 2'd1; pj = 2'd3; end
         default: begin pi = 2'd2; pj = 2'd3; end
      endcase
   end

   // Ties compare as "not smaller" on both axes, so an all-tied pair counts as concordant.
   assign sx         = x_q[pi] < x_q[pj];
   assign sy         = y_q[pi] < y_q[pj];
   assign concordant = ~(sx ^ sy);
   assign acc_sum    = acc_q + {2'b00, concordant};

   always_comb begin
      state_d    = state_q;
      pt_idx_d   = pt_idx_q;
      pair_idx_d = pair_idx_q;
      acc_d      = acc_q;
      x_d        = x_q;
      y_d        = y_q;
      kendall_d  = kendall_q;
      conc_d     = conc_q;
      case (state_q)
         S_LOAD: begin
            if (in_valid) begin
               x_d[pt_idx_q] = in_x;
               y_d[pt_idx_q] = in_y;
               pt_idx_d      = pt_idx_q + 2'd1;
               if (pt_idx_q == 2'd3) begin
                  state_d    = S_CALC;
                  pt_idx_d   = 2'd0;
                  pair_idx_d = 3'd0;
                  acc_d      = 3'd0;
               end
            end
         end
         S_CALC: begin
            acc_d      = acc_sum;
            pair_idx_d = pair_idx_q + 3'd1;
            if (pair_idx_q == 3'd5) begin
               state_d    = S_DONE;
               conc_d     = acc_sum;
               kendall_d  = tau6(acc_sum);
               pair_idx_d = 3'd0;
               acc_d      = 3'd0;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_LOAD;
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_LOAD;
         pt_idx_q   <= 2'd0;
         pair_idx_q <= 3'd0;
         acc_q      <= 3'd0;
         kendall_q  <= 4'sd0;
         conc_q     <= 3'd0;
         for (int k = 0; k < 4; k++) begin
            x_q[k] <= '0;
            y_q[k] <= '0;
         end
      end else begin
         state_q    <= state_d;
         pt_idx_q   <= pt_idx_d;
         pair_idx_q <= pair_idx_d;
         acc_q      <= acc_d;
         kendall_q  <= kendall_d;
         conc_q     <= conc_d;
         x_q        <= x_d;
         y_q        <= y_d;
      end
   end

   // Handshake outputs decode straight from the state register.
   assign in_ready  = (state_q == S_LOAD);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_CALC);
   assign kendall   = kendall_q;
   assign conc_cnt  = conc_q;

endmodule

// File: tb/tb_kendall_seq_ctrl.sv
// Randomized bench for kendall_seq_ctrl against a pairwise rank-counting model.
module tb_kendall_seq_ctrl;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_x, in_y;
   logic              out_valid;
   logic              out_ready;
   logic signed [3:0] kendall;
   logic [2:0]        conc_cnt;
   logic              busy;

   int total = 0;
   int bad   = 0;
   logic [3:0] set_x [4];
   logic [3:0] set_y [4];

   always #5 clk = ~clk;

   kendall_seq_ctrl #(.DW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .kendall   (kendall),
      .conc_cnt  (conc_cnt),
      .busy      (busy)
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Count pairs i<j whose x and y orderings agree (strict less-than on both).
   function automatic int model_c();
      int c = 0;
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            if ((set_x[i] < set_x[j]) == (set_y[i] < set_y[j])) c++;
      return c;
   endfunction

   task automatic load_set(input logic [15:0] xs, input logic [15:0] ys);
      for (int k = 0; k < 4; k++) begin
         set_x[k] = xs[k*4 +: 4];
         set_y[k] = ys[k*4 +: 4];
      end
   endtask

   // Presents the four points; returns just after the accepting edge of point 4.
   task automatic feed4(input int gapped);
      for (int k = 0; k < 4; k++) begin
         if (gapped != 0) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               in_valid = 1'b0;
               in_x = 4'($urandom);
               in_y = 4'($urandom);
            end
         end
         @(negedge clk);
         chk("in_ready_load", int'(in_ready), 1);
         in_valid = 1'b1;
         in_x = set_x[k];
         in_y = set_y[k];
      end
      @(posedge clk);
   endtask

   task automatic finish_set(input int hold_valid, input int bp);
      int c, ek, n;
      c  = model_c();
      ek = 2 * c - 6;
      n  = 0;
      @(negedge clk);
      in_valid = (hold_valid != 0);
      in_x = 4'($urandom);
      in_y = 4'($urandom);
      while (!out_valid && n < 20) begin
         chk("busy_calc", int'(busy), 1);
         chk("in_ready_calc", int'(in_ready), 0);
         @(negedge clk);
         n++;
      end
      chk("latency", n, 6);
      chk("conc_cnt", int'(conc_cnt), c);
      chk("kendall", int'(kendall), ek);
      chk("busy_done", int'(busy), 0);
      for (int b = 0; b < bp; b++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_x      = 4'($urandom);
         in_y      = 4'($urandom);
         out_ready = 1'b0;
         @(negedge clk);
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_kendall", int'(kendall), ek);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_out_valid", int'(out_valid), 0);
      chk("post_in_ready", int'(in_ready), 1);
      chk("post_kendall_held", int'(kendall), ek);
      chk("post_conc_held", int'(conc_cnt), c);
   endtask

   task automatic run_set(input int gapped, input int hold_valid, input int bp);
      feed4(gapped);
      finish_set(hold_valid, bp);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, int'(in_ready), 1);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_kendall"}, int'(kendall), 0);
      chk({tag, "_conc"}, int'(conc_cnt), 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;

      load_set(16'h3210, 16'h3210);   // monotone
      run_set(0, 0, 0);
      load_set(16'h3210, 16'h0123);   // anti
      run_set(0, 0, 5);
      load_set(16'h3210, 16'h2301);   // mixed
      run_set(1, 0, 2);
      load_set(16'h5555, 16'h3210);   // x ties
      run_set(0, 1, 0);
      load_set(16'h7777, 16'h7777);   // all equal
      run_set(1, 1, 3);

      // Reset in the middle of a CALC, then a clean monotone set
      load_set(16'h3210, 16'h3210);
      feed4(0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      run_set(0, 0, 0);

      for (int t = 0; t < 40; t++) begin
         for (int k = 0; k < 4; k++) begin
            if (t % 3 == 0) begin
               set_x[k] = 4'($urandom_range(0, 2));
               set_y[k] = 4'($urandom_range(0, 2));
            end else begin
               set_x[k] = 4'($urandom);
               set_y[k] = 4'($urandom);
            end
         end
         run_set(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 4)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
